// File: rtl/rf_mp.sv
// rf_mp: parametrised multi-port register file for the decode stage.
// Two write ports (port 1 wins on an address clash) and NUM_RD
// combinational read ports. An optional bypass forwards same-cycle
// write data to the reads. A per-register pending scoreboard flags
// destinations reserved by in-flight instructions.
// Register 0 is hardwired to zero and never pending.
// Strobe semantics: every input is a level sampled at the rising edge.
// There is no backpressure. A write or reserve presented with its enable
// high is always accepted in that cycle (unless rst is high).
module rf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3,
    parameter int BYPASS = 1,
    parameter int TRACE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic [31:0]                pc0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [31:0]                pc1,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr
);

    localparam int NREG = 1 << ADDR_W;

    // Storage for registers 1..NREG-1; register 0 has no flops.
    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1]   pend_q;
    logic [NREG-1:1]   pend_d;

    // Qualified write/reserve strobes: address 0 is never a target.
    logic w0_en;
    logic w1_en;
    logic w0_keep;
    logic rsv_ok;

    assign w0_en   = we0 && (wa0 != '0);
    assign w1_en   = we1 && (wa1 != '0);
    // Port 0 loses when both ports target the same register.
    assign w0_keep = w0_en && !(w1_en && (wa1 == wa0));
    assign rsv_ok  = rsv_en && (rsv_addr != '0);

    // Next-state register contents: port 0 first, port 1 overrides.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (w0_keep) begin
            regs_d[wa0] = wd0;
        end
        if (w1_en) begin
            regs_d[wa1] = wd1;
        end
    end

    // Next-state scoreboard: writes retire, then a reserve from the younger
    // instruction re-arms the bit, so a same-cycle reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (w0_en) begin
            pend_d[wa0] = 1'b0;
        end
        if (w1_en) begin
            pend_d[wa1] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    // State registers; reset discards any write or reserve in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Read ports: zero-latency lookup with optional same-cycle forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] stored;
        logic              pend_raw;

        assign ra       = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit0     = w0_en && (wa0 == ra);
        assign hit1     = w1_en && (wa1 == ra);
        assign stored   = (ra == '0) ? '0 : regs_q[ra];
        assign pend_raw = (ra == '0) ? 1'b0 : pend_q[ra];

        if (BYPASS != 0) begin : g_byp
            assign rd_data[k*DATA_W +: DATA_W] = hit1 ? wd1 :
                                                 hit0 ? wd0 : stored;
            // A write landing this cycle satisfies the hazard already.
            assign rd_pending[k] = pend_raw && !(hit0 || hit1);
        end else begin : g_nobyp
            assign rd_data[k*DATA_W +: DATA_W] = stored;
            assign rd_pending[k] = pend_raw;
        end
    end

    // PCs only feed the trace; fold them so they are visibly consumed.
    logic unused_pc;
    assign unused_pc = ^{pc0, pc1};

    // Commit trace: one line per stored write; an overridden port 0 is silent.
    if (TRACE != 0) begin : g_trace
`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (!rst) begin
                if (w0_keep) begin
                    $display("@%h: $%d <= %h", pc0, wa0, wd0);
                end
                if (w1_en) begin
                    $display("@%h: $%d <= %h", pc1, wa1, wd1);
                end
            end
        end
`endif
    end

endmodule
